// File: rtl/fdd_cache_pkg.sv
// Shared types and helpers for the floppy track cache: FSM states, sector geometry
// and the track/sector to LBA mapping.
package fdd_cache_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned SECTOR_AW    = 9;

    typedef enum logic [2:0] {
        StIdle,
        StFlushReq,
        StFlushWait,
        StLoadReq,
        StLoadWait
    } state_e;

    function automatic logic [31:0] track_lba(input logic [31:0] track,
                                              input logic [31:0] sec,
                                              input int unsigned spt);
        return 32'(track * spt + sec);
    endfunction

endpackage

// File: rtl/fdd_track_cache_bram.sv
// Dual-port byte RAM holding one track: port A faces the SD block interface, port B the
// disk controller. Both ports read-first with one cycle of read latency.
module fdd_track_cache_bram #(
    parameter int unsigned DataW = 8,
    parameter int unsigned AddrW = 13
) (
    input  logic             clk_i,
    input  logic [AddrW-1:0] a_addr_i,
    input  logic             a_we_i,
    input  logic [DataW-1:0] a_wdata_i,
    output logic [DataW-1:0] a_rdata_o,
    input  logic [AddrW-1:0] b_addr_i,
    input  logic             b_we_i,
    input  logic [DataW-1:0] b_wdata_i,
    output logic [DataW-1:0] b_rdata_o
);

    logic [DataW-1:0] mem_q [2**AddrW];

    // The cache never writes both ports in the same cycle, so one process suffices.
    always_ff @(posedge clk_i) begin
        if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
        if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
        a_rdata_o <= mem_q[a_addr_i];
        b_rdata_o <= mem_q[b_addr_i];
    end

endmodule

// File: rtl/fdd_track_cache.sv
// Multi-drive floppy track cache: loads a whole track over the SD handshake on a miss and
// stalls the CPU meanwhile. Define FDD_WRITEBACK_EN for dirty tracking and sector write-back.
module fdd_track_cache
    import fdd_cache_pkg::*;
#(
    parameter int unsigned DRIVES            = 2,
    parameter int unsigned SECTORS_PER_TRACK = 13,
    parameter int unsigned TRACK_W           = 6,
    parameter int unsigned BUF_AW            = 13,
    localparam int unsigned DrvW             = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
    input  logic               CLK_VIDEO,
    input  logic               reset,
    input  logic [DrvW-1:0]    drive_sel_i,
    input  logic [TRACK_W-1:0] track_i,
    input  logic [DRIVES-1:0]  img_mounted_i,
    input  logic [DRIVES-1:0]  img_present_i,
    output logic               cpu_wait_o,
    output logic [31:0]        sd_lba_o,
    output logic [DRIVES-1:0]  sd_rd_o,
    output logic [DRIVES-1:0]  sd_wr_o,
    input  logic [DRIVES-1:0]  sd_ack_i,
    input  logic [8:0]         sd_buff_addr_i,
    input  logic [7:0]         sd_buff_dout_i,
    input  logic               sd_buff_wr_i,
    output logic [7:0]         sd_buff_din_o,
    input  logic [BUF_AW-1:0]  fd_track_addr_i,
    input  logic [7:0]         fd_data_out_i,
    input  logic               fd_write_i,
    output logic [7:0]         fd_data_in_o,
    output logic               buf_valid_o
);

    localparam int unsigned     SecW    = BUF_AW - SECTOR_AW;
    localparam logic [SecW-1:0] LastSec = SecW'(SECTORS_PER_TRACK - 1);

    state_e             state_q;
    logic [DrvW-1:0]    cur_drive_q;
    logic [TRACK_W-1:0] cur_track_q;
    logic [SecW-1:0]    sec_q;
    logic               valid_q;
    logic               cpu_wait_q;
    logic               ack_q;
    logic [31:0]        sd_lba_q;
    logic [DRIVES-1:0]  sd_rd_q;

    logic              ack_cur, ack_rise, ack_fall;
    logic              present, tag_change, miss, pending;
    logic [DRIVES-1:0] lane_sel;
    logic              a_we, b_we;
    logic [7:0]        b_rdata;

    assign ack_cur    = sd_ack_i[cur_drive_q];
    assign ack_rise   = ack_cur && !ack_q;
    assign ack_fall   = !ack_cur && ack_q;
    assign present    = img_present_i[drive_sel_i];
    assign tag_change = (drive_sel_i != cur_drive_q) || (track_i != cur_track_q) ||
                        img_mounted_i[drive_sel_i];
    assign miss       = present && (tag_change || !valid_q);
    // A change seen while a load finishes keeps the CPU stalled straight into the reload.
    assign pending    = present && tag_change;
    assign lane_sel   = DRIVES'(1) << cur_drive_q;
    assign a_we       = (state_q == StLoadWait) && sd_buff_wr_i && ack_cur;

`ifdef FDD_WRITEBACK_EN
    logic [SECTORS_PER_TRACK-1:0] dirty_q;
    logic [DRIVES-1:0]            sd_wr_q;
    logic [SecW-1:0]              low_dirty;
    logic [SecW-1:0]              fd_sec;

    assign fd_sec = fd_track_addr_i[BUF_AW-1 -: SecW];
    // Writes racing a miss are dropped so no dirty bit outlives the tag it belongs to.
    assign b_we   = fd_write_i && valid_q && (state_q == StIdle) && !miss;

    always_comb begin
        low_dirty = '0;
        for (int i = SECTORS_PER_TRACK - 1; i >= 0; i--) begin
            if (dirty_q[i]) low_dirty = SecW'(i);
        end
    end

    assign sd_wr_o = reset ? '0 : sd_wr_q;
`else
    logic unused_fd_write;
    assign unused_fd_write = fd_write_i;
    assign b_we            = 1'b0;
    assign sd_wr_o         = '0;
`endif

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_drive_q <= '0;
            cur_track_q <= '0;
            sec_q       <= '0;
            valid_q     <= 1'b0;
            cpu_wait_q  <= 1'b0;
            ack_q       <= 1'b0;
            sd_lba_q    <= '0;
            sd_rd_q     <= '0;
`ifdef FDD_WRITEBACK_EN
            dirty_q     <= '0;
            sd_wr_q     <= '0;
`endif
        end else begin
            ack_q <= ack_cur;
`ifdef FDD_WRITEBACK_EN
            if (b_we && (fd_sec < SecW'(SECTORS_PER_TRACK))) dirty_q[fd_sec] <= 1'b1;
`endif
            unique case (state_q)
                StIdle: begin
                    if (miss) begin
                        cpu_wait_q <= 1'b1;
                        valid_q    <= 1'b0;
`ifdef FDD_WRITEBACK_EN
                        if (|dirty_q) begin
                            sec_q   <= low_dirty;
                            state_q <= StFlushReq;
                        end else
`endif
                        begin
                            cur_drive_q <= drive_sel_i;
                            cur_track_q <= track_i;
                            sec_q       <= '0;
                            state_q     <= StLoadReq;
                        end
                    end else begin
                        cpu_wait_q <= 1'b0;
                        if (tag_change) valid_q <= 1'b0;
                    end
                end
`ifdef FDD_WRITEBACK_EN
                StFlushReq: begin
                    sd_lba_q <= track_lba(32'(cur_track_q), 32'(sec_q), SECTORS_PER_TRACK);
                    sd_wr_q  <= lane_sel;
                    state_q  <= StFlushWait;
                end
                StFlushWait: begin
                    if (ack_rise) begin
                        sd_wr_q        <= '0;
                        dirty_q[sec_q] <= 1'b0;
                    end
                    if (ack_fall) begin
                        if (|dirty_q) begin
                            sec_q   <= low_dirty;
                            state_q <= StFlushReq;
                        end else begin
                            cur_drive_q <= drive_sel_i;
                            cur_track_q <= track_i;
                            sec_q       <= '0;
                            state_q     <= StLoadReq;
                        end
                    end
                end
`endif
                StLoadReq: begin
                    sd_lba_q <= track_lba(32'(cur_track_q), 32'(sec_q), SECTORS_PER_TRACK);
                    sd_rd_q  <= lane_sel;
                    state_q  <= StLoadWait;
                end
                StLoadWait: begin
                    if (ack_rise) sd_rd_q <= '0;
                    if (ack_fall) begin
                        if (sec_q == LastSec) begin
                            valid_q    <= 1'b1;
                            cpu_wait_q <= pending;
                            state_q    <= StIdle;
                        end else begin
                            sec_q   <= sec_q + 1'b1;
                            state_q <= StLoadReq;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fdd_track_cache_bram #(
        .DataW (8),
        .AddrW (BUF_AW)
    ) u_buf (
        .clk_i     (CLK_VIDEO),
        .a_addr_i  ({sec_q, sd_buff_addr_i}),
        .a_we_i    (a_we),
        .a_wdata_i (sd_buff_dout_i),
        .a_rdata_o (sd_buff_din_o),
        .b_addr_i  (fd_track_addr_i),
        .b_we_i    (b_we),
        .b_wdata_i (fd_data_out_i),
        .b_rdata_o (b_rdata)
    );

    assign cpu_wait_o   = cpu_wait_q;
    assign sd_lba_o     = sd_lba_q;
    assign sd_rd_o      = reset ? '0 : sd_rd_q;
    assign buf_valid_o  = valid_q;
    assign fd_data_in_o = valid_q ? b_rdata : 8'hFF;

endmodule

// File: tb/tb_fdd_track_cache.sv
// Bench for fdd_track_cache: an SD responder checks each request against a queue of
// expected transfers and feeds a known byte pattern; buffer reads are checked against it.
module tb_fdd_track_cache;

    localparam int unsigned SPT = 13;

    typedef struct {
        bit         wr;
        int         lane;
        int         lba;
        int         addr;
        logic [7:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:0]  drive_sel;
    logic [5:0]  track;
    logic [1:0]  img_mounted;
    logic [1:0]  img_present;
    logic        cpu_wait;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd;
    logic [1:0]  sd_wr;
    logic [1:0]  sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [12:0] fd_track_addr;
    logic [7:0]  fd_data_out;
    logic        fd_write;
    logic [7:0]  fd_data_in;
    logic        buf_valid;

    int   n_checks = 0;
    int   n_errors = 0;
    req_t exp_q[$];
    bit   watch_wait = 1'b0;
    int   wait_drops = 0;

    fdd_track_cache u_dut (
        .CLK_VIDEO       (clk),
        .reset           (reset),
        .drive_sel_i     (drive_sel),
        .track_i         (track),
        .img_mounted_i   (img_mounted),
        .img_present_i   (img_present),
        .cpu_wait_o      (cpu_wait),
        .sd_lba_o        (sd_lba),
        .sd_rd_o         (sd_rd),
        .sd_wr_o         (sd_wr),
        .sd_ack_i        (sd_ack),
        .sd_buff_addr_i  (sd_buff_addr),
        .sd_buff_dout_i  (sd_buff_dout),
        .sd_buff_wr_i    (sd_buff_wr),
        .sd_buff_din_o   (sd_buff_din),
        .fd_track_addr_i (fd_track_addr),
        .fd_data_out_i   (fd_data_out),
        .fd_write_i      (fd_write),
        .fd_data_in_o    (fd_data_in),
        .buf_valid_o     (buf_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch_wait && !cpu_wait) wait_drops++;
    end

    function automatic logic [7:0] pat(input int lba, input int a);
        return 8'(lba * 37 + a * 5 + 27);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_load(input int lane, input int trk);
        for (int s = 0; s < SPT; s++) begin
            exp_q.push_back('{wr: 1'b0, lane: lane, lba: trk * SPT + s, addr: 0, data: 8'h00});
        end
    endtask

    // Serves one SD request; new_track >= 0 moves the head while the sector is transferring.
    task automatic serve_one(input int new_track);
        int   t;
        req_t e;
        t = 0;
        while ((sd_rd | sd_wr) == 2'b00 && t < 300) begin
            step();
            t++;
        end
        check_val("req_seen", 32'((sd_rd | sd_wr) != 2'b00), 32'd1);
        if ((sd_rd | sd_wr) == 2'b00) return;
        if (exp_q.size() == 0) begin
            check_val("req_expected", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_val("sd_lba", sd_lba, 32'(e.lba));
        check_val("sd_rd_lane", 32'(sd_rd), e.wr ? 32'd0 : 32'(1 << e.lane));
        check_val("sd_wr_lane", 32'(sd_wr), e.wr ? 32'(1 << e.lane) : 32'd0);
        check_val("cpu_wait_busy", 32'(cpu_wait), 32'd1);
        sd_ack = '0;
        sd_ack[e.lane] = 1'b1;
        step();
        if (e.wr) begin
            sd_buff_addr = 9'(e.addr);
            step();
            check_val("flush_byte", 32'(sd_buff_din), 32'(e.data));
        end else begin
            for (int a = 0; a < 8; a++) begin
                sd_buff_addr = 9'(a);
                sd_buff_dout = pat(e.lba, a);
                sd_buff_wr   = 1'b1;
                if (a == 3 && new_track >= 0) begin
                    track = 6'(new_track);
                    push_load(int'(drive_sel), new_track);
                end
                step();
            end
            sd_buff_wr = 1'b0;
        end
        check_val("req_dropped", 32'(sd_rd | sd_wr), 32'd0);
        sd_ack = '0;
        step();
    endtask

    task automatic serve_n(input int n);
        for (int i = 0; i < n; i++) serve_one(-1);
    endtask

    task automatic rd_check(input string tag, input int addr, input logic [7:0] exp);
        fd_track_addr = 13'(addr);
        step();
        check_val(tag, 32'(fd_data_in), 32'(exp));
    endtask

    initial begin
        int t;
        reset = 1'b1;
        drive_sel = '0;
        track = '0;
        img_mounted = '0;
        img_present = '0;
        sd_ack = '0;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        sd_buff_wr = 1'b0;
        fd_track_addr = '0;
        fd_data_out = '0;
        fd_write = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        check_val("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        check_val("rst_sd_rd", 32'(sd_rd), 32'd0);
        check_val("rst_sd_wr", 32'(sd_wr), 32'd0);
        check_val("rst_sd_lba", sd_lba, 32'd0);
        check_val("rst_buf_valid", 32'(buf_valid), 32'd0);
        check_val("rst_fd_data", 32'(fd_data_in), 32'hFF);

        // Mount drive 0 at track 0.
        img_present = 2'b01;
        img_mounted = 2'b01;
        push_load(0, 0);
        step();
        img_mounted = 2'b00;
        serve_n(SPT);
        check_val("load0_valid", 32'(buf_valid), 32'd1);
        check_val("load0_wait", 32'(cpu_wait), 32'd0);
        rd_check("load0_sec1_b0", 'h0200, pat(1, 0));
        rd_check("load0_sec0_b0", 'h0000, pat(0, 0));
        rd_check("load0_sec12_b7", 'h1807, pat(12, 7));

        // Track 0 -> 5.
        track = 6'd5;
        push_load(0, 5);
        serve_n(SPT);
        check_val("trk5_wait", 32'(cpu_wait), 32'd0);
        check_val("trk5_valid", 32'(buf_valid), 32'd1);
        rd_check("trk5_sec2_b3", 'h0403, pat(67, 3));

        // Controller write at 0x0A05 (sector 5, byte 5), then a track change.
        fd_track_addr = 13'h0A05;
        fd_data_out = 8'hC3;
        fd_write = 1'b1;
        step();
        fd_write = 1'b0;
        step();
`ifdef FDD_WRITEBACK_EN
        check_val("fd_write_readback", 32'(fd_data_in), 32'hC3);
        track = 6'd6;
        exp_q.push_back('{wr: 1'b1, lane: 0, lba: 5 * SPT + 5, addr: 5, data: 8'hC3});
        push_load(0, 6);
        serve_n(1 + SPT);
`else
        check_val("fd_write_ignored", 32'(fd_data_in), 32'(pat(70, 5)));
        track = 6'd6;
        push_load(0, 6);
        serve_n(SPT);
`endif
        check_val("trk6_valid", 32'(buf_valid), 32'd1);
        rd_check("trk6_sec5_b5", 'h0A05, pat(83, 5));

        // Drive 0 -> 1 on the same track: only lane 1 may request.
        img_present = 2'b11;
        drive_sel = 1'b1;
        push_load(1, 6);
        serve_n(SPT);
        check_val("drv1_valid", 32'(buf_valid), 32'd1);
        rd_check("drv1_sec4_b1", 'h0801, pat(82, 1));

        // Track change during sector 6: load completes, reload follows without a stall gap.
        track = 6'd9;
        push_load(1, 9);
        serve_one(-1);
        watch_wait = 1'b1;
        serve_n(5);
        serve_one(10);
        serve_n(6 + SPT - 1);
        watch_wait = 1'b0;
        serve_one(-1);
        check_val("reload_wait_no_drop", 32'(wait_drops), 32'd0);
        check_val("reload_wait_done", 32'(cpu_wait), 32'd0);
        check_val("reload_valid", 32'(buf_valid), 32'd1);
        rd_check("reload_sec0_b0", 'h0000, pat(130, 0));
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a sector transfer.
        track = 6'd11;
        t = 0;
        while (sd_rd == 2'b00 && t < 300) begin
            step();
            t++;
        end
        check_val("mid_req_seen", 32'(sd_rd), 32'b10);
        sd_ack = 2'b10;
        step();
        step();
        reset = 1'b1;
        img_present = 2'b00;
        sd_ack = '0;
        step();
        check_val("mid_rst_sd_rd", 32'(sd_rd), 32'd0);
        check_val("mid_rst_wait", 32'(cpu_wait), 32'd0);
        check_val("mid_rst_valid", 32'(buf_valid), 32'd0);
        check_val("mid_rst_fd_data", 32'(fd_data_in), 32'hFF);
        reset = 1'b0;
        repeat (3) step();
        check_val("post_rst_idle", 32'(sd_rd), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fdd_track_cache.md
# fdd_track_cache

Multi-drive floppy track cache between the Apple II disk controller and the SD block interface. Holds one full track (SECTORS_PER_TRACK × 512 bytes) for the active drive, fetches it sector by sector over the sd_rd/sd_ack handshake on any track, drive or mount change, and stalls the CPU while doing so. Sectors written by the controller are marked dirty and written back to the image before the buffer is reused.

## Interface
- DRIVES, 2: number of drive channels; one sd_rd/sd_wr/sd_ack lane each.
- SECTORS_PER_TRACK, 13: 512-byte SD sectors per track.
- TRACK_W, 6: track number width.
- BUF_AW, 13: track buffer byte address width; must satisfy 2^BUF_AW ≥ SECTORS_PER_TRACK·512.

- CLK_VIDEO  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- drive_sel  in  $clog2(DRIVES)  active drive.
- track  in  TRACK_W  head position of the active drive.
- img_mounted  in  DRIVES  one-cycle pulse per drive on image (re)mount.
- img_present  in  DRIVES  level; image size non-zero.
- cpu_wait  out  1  CPU stall.
- sd_lba  out  32  sector LBA for the current request.
- sd_rd / sd_wr  out  DRIVES  per-lane request.
- sd_ack  in  DRIVES  per-lane acknowledge.
- sd_buff_addr  in  9; sd_buff_dout  in  8; sd_buff_wr  in  1; sd_buff_din  out  8  SD byte port.
- fd_track_addr  in  BUF_AW; fd_data_out  in  8; fd_write  in  1; fd_data_in  out  8  controller byte port.
- buf_valid  out  1  buffer holds a loaded track for the active drive/track.

## Operation
- Tag registers: cur_drive, cur_track, valid, dirty[SECTORS_PER_TRACK], sec counter.
- FSM states: IDLE, FLUSH_REQ, FLUSH_WAIT, LOAD_REQ, LOAD_WAIT.
- IDLE: a miss is (drive_sel≠cur_drive) | (track≠cur_track) | img_mounted[drive_sel] | ~valid while img_present[drive_sel]. On a miss:
  - any dirty → FLUSH_REQ with sec = lowest dirty index;
  - otherwise → latch the new tag and go to LOAD_REQ with sec = 0.
  - The new tag is not latched before the flush completes.
- FLUSH_REQ: sd_lba = cur_track·SECTORS_PER_TRACK + sec; sd_wr[cur_drive]=1. Go to FLUSH_WAIT.
- FLUSH_WAIT:
  - rising sd_ack: drop sd_wr; clear dirty[sec].
  - falling sd_ack: go to the next dirty sector (FLUSH_REQ), or, if none remain, latch the new tag and go to LOAD_REQ.
- LOAD_REQ: sd_lba = track·SECTORS_PER_TRACK + sec; sd_rd[cur_drive]=1.
- LOAD_WAIT:
  - rising sd_ack drops sd_rd.
  - Bytes are written at {sec, sd_buff_addr} while sd_buff_wr & sd_ack[cur_drive].
  - On falling ack: sec+1. When sec = SECTORS_PER_TRACK−1, set valid=1 and return to IDLE.
- IDLE rechecks the miss condition on its first cycle, so a track change during a load causes an immediate reload.
- img_present low on a miss: valid=0, no SD traffic. fd_data_in reads 8'hFF while ~valid.
- fd_write when valid & IDLE: write byte, set dirty[fd_track_addr / 512]. fd_write in any other state is dropped.
- Multiplication: TRACK_W × constant, zero-extended to 32 bits.

## Timing
- Reset values: cpu_wait=0, sd_rd=0, sd_wr=0, sd_lba=0, buf_valid=0, fd_data_in=8'hFF; valid, dirty and tags cleared.
- Reset mid-transfer drops requests in the same cycle and discards dirty data.
- cpu_wait=1 from the cycle after miss detection until the cycle IDLE is re-entered.
- fd_data_in and sd_buff_din: one-cycle registered read latency.
- Requests stay high until the rising edge of sd_ack. Only one lane is active at a time.
- sd_buff_din presents buffer data at {sec, sd_buff_addr} during flush.

## Configuration
- FDD_WRITEBACK_EN defined: dirty tracking and the flush states as above.
- Undefined:
  - fd_write is ignored and the buffer is read-only from the controller side.
  - sd_wr is tied to 0 and the FLUSH states are not generated.
  - A miss goes straight to LOAD_REQ.

## Structure
- Package fdd_cache_pkg holds:
  - state enum;
  - SECTOR_BYTES=512;
  - function track_lba(track, sec, spt).
- Sub-module: the existing dual-port bram #(8, BUF_AW).
  - Port A: SD side.
  - Port B: controller side.

## Test plan
- Mount pulse on drive 0, track=0, img_present=1 → 13 reads, LBAs 0..12; cpu_wait high throughout; buf_valid=1 after the last falling ack; fd_track_addr=0x0200 returns byte 0 of LBA 1.
- track 0→5 → reads at LBAs 65..77; cpu_wait deasserts one cycle after the final falling ack.
- (WRITEBACK_EN) fd_write at addr 0x0A05, then track change → one sd_wr at LBA cur_track·13+5 with that byte on sd_buff_din at addr 5, followed by a 13-sector load.
- drive_sel 0→1 with same track → sd_rd[1] only, sd_rd[0] stays 0.
- track changes during sector 6 of a load → load finishes, then an immediate reload of the new track without cpu_wait dropping.
- reset asserted mid-LOAD_WAIT → next cycle sd_rd=0, cpu_wait=0, buf_valid=0, fd_data_in=8'hFF.
